ps2_scancode_decoder: RTL and testbench

- Sits directly downstream of the PS/2 byte receiver. Consumes its 8-bit scan code and its one-cycle done strobe.
- Assembles Set-2 multi-byte sequences (E0 extended, F0 break, E1 pause) into single key events, tracks modifier state and buffers events in a small FWFT FIFO for the consumer.
- Drives the receiver's enable so bytes are not accepted while the FIFO is full.

---
 rtl/ps2_scancode_decoder.sv | 221 ++++++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scancode_decoder
// Description : Set-2 scan code assembler with modifier tracking, typematic
//               repeat filter and a small first-word-fall-through event FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_scancode_decoder #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int TO_W           = 21,
    parameter int FILTER_REPEAT  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] scan_code,
    output logic       rx_en,
    input  logic       ev_rd,
    output logic [9:0] ev_data,
    output logic       ev_empty,
    output logic       ev_ovf,
    input  logic       ovf_clr,
    output logic       seq_err,
    output logic       shift,
    output logic       ctrl,
    output logic       alt,
    output logic       caps_lock
);

    localparam int                AW      = $clog2(DEPTH);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]       FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXT     = 3'd1,
        S_BRK     = 3'd2,
        S_EXT_BRK = 3'd3,
        S_PAUSE   = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [2:0]      skip;
    logic [TO_W-1:0] to_cnt;
    logic            emit, emit_ext, emit_brk, abort;
    logic [7:0]      emit_code;
    logic [8:0]      key;
    logic [8:0]      last_key;
    logic            last_valid;
    logic            repeat_hit, push_req;
    logic            lshift, rshift, lctrl, rctrl, lalt, ralt, caps_held;
    logic            is_prefix, is_filler;

    logic [9:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            full, do_push, do_pop;

    assign is_prefix = (scan_code == 8'hE0) || (scan_code == 8'hF0) || (scan_code == 8'hE1);
    assign is_filler = (scan_code == 8'hAA) || (scan_code == 8'hFA) || (scan_code == 8'hEE) ||
                       (scan_code == 8'hFE) || (scan_code == 8'h00) || (scan_code == 8'hFF);

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        emit_ext  = 1'b0;
        emit_brk  = 1'b0;
        abort     = 1'b0;
        emit_code = scan_code;
        if (rx_done_tick) begin
            case (state)
                S_IDLE: begin
                    if (scan_code == 8'hE0)      state_nxt = S_EXT;
                    else if (scan_code == 8'hF0) state_nxt = S_BRK;
                    else if (scan_code == 8'hE1) state_nxt = S_PAUSE;
                    else if (!is_filler)         emit = 1'b1;
                end
                S_EXT: begin
                    state_nxt = S_IDLE;
                    if (scan_code == 8'hF0)      state_nxt = S_EXT_BRK;
                    else if (scan_code == 8'h12) emit = 1'b0;
                    else if (is_prefix)          abort = 1'b1;
                    else begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                    end
                end
                S_BRK: begin
                    state_nxt = S_IDLE;
                    if (is_prefix) abort = 1'b1;
                    else begin
                        emit     = 1'b1;
                        emit_brk = 1'b1;
                    end
                end
                S_EXT_BRK: begin
                    state_nxt = S_IDLE;
                    if (scan_code == 8'h12) emit = 1'b0;
                    else if (is_prefix)     abort = 1'b1;
                    else begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        emit_brk = 1'b1;
                    end
                end
                S_PAUSE: begin
                    // Pause is reported as an extended make of 0x77 once its tail is consumed
                    if (skip == 3'd1) begin
                        state_nxt = S_IDLE;
                        emit      = 1'b1;
                        emit_ext  = 1'b1;
                        emit_code = 8'h77;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign key        = {emit_ext, emit_code};
    assign repeat_hit = (FILTER_REPEAT != 0) && last_valid && (last_key == key);
    assign push_req   = emit && (emit_brk || !repeat_hit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            skip       <= 3'd0;
            to_cnt     <= '0;
            seq_err    <= 1'b0;
            last_key   <= '0;
            last_valid <= 1'b0;
            lshift     <= 1'b0;
            rshift     <= 1'b0;
            lctrl      <= 1'b0;
            rctrl      <= 1'b0;
            lalt       <= 1'b0;
            ralt       <= 1'b0;
            caps_held  <= 1'b0;
            caps_lock  <= 1'b0;
        end else begin
            seq_err <= 1'b0;
            if (rx_done_tick) begin
                state   <= state_nxt;
                to_cnt  <= '0;
                seq_err <= abort;
                if (state == S_IDLE && scan_code == 8'hE1) skip <= 3'd7;
                else if (state == S_PAUSE)                 skip <= skip - 3'd1;
            end else if (state != S_IDLE) begin
                if (to_cnt == TO_LAST) begin
                    state   <= S_IDLE;
                    to_cnt  <= '0;
                    seq_err <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end else begin
                to_cnt <= '0;
            end

            if (emit) begin
                case (key)
                    9'h012: lshift <= !emit_brk;
                    9'h059: rshift <= !emit_brk;
                    9'h014: lctrl  <= !emit_brk;
                    9'h114: rctrl  <= !emit_brk;
                    9'h011: lalt   <= !emit_brk;
                    9'h111: ralt   <= !emit_brk;
                    9'h058: begin
                        if (!emit_brk && !caps_held) caps_lock <= ~caps_lock;
                        caps_held <= !emit_brk;
                    end
                    default: ;
                endcase
                if (!emit_brk && push_req) begin
                    last_key   <= key;
                    last_valid <= 1'b1;
                end else if (emit_brk && last_valid && last_key == key) begin
                    last_valid <= 1'b0;
                end
            end
        end
    end

    assign shift = lshift | rshift;
    assign ctrl  = lctrl | rctrl;
    assign alt   = lalt | ralt;

    assign full     = (count == FULL_CNT);
    assign ev_empty = (count == '0);
    assign rx_en    = ~full;
    assign do_pop   = ev_rd && !ev_empty;
    // A pop in the same cycle frees the slot the push needs
    assign do_push  = push_req && (!full || do_pop);
    assign ev_data  = ev_empty ? 10'd0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {emit_ext, emit_brk, emit_code};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ev_ovf <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push_req && !do_push) ev_ovf <= 1'b1;
            else if (ovf_clr)         ev_ovf <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_scancode_decoder
// Description : Directed and randomized bench with a sequence-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 4;
    localparam int TOC   = 50;
    localparam int TO_W  = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] scan_code;
    logic       rx_en;
    logic       ev_rd;
    logic [9:0] ev_data;
    logic       ev_empty;
    logic       ev_ovf;
    logic       ovf_clr;
    logic       seq_err;
    logic       shift, ctrl, alt, caps_lock;

    ps2_scancode_decoder #(
        .DEPTH(DEPTH), .TIMEOUT_CYCLES(TOC), .TO_W(TO_W), .FILTER_REPEAT(1)
    ) dut (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .scan_code(scan_code),
        .rx_en(rx_en), .ev_rd(ev_rd), .ev_data(ev_data), .ev_empty(ev_empty),
        .ev_ovf(ev_ovf), .ovf_clr(ovf_clr), .seq_err(seq_err), .shift(shift),
        .ctrl(ctrl), .alt(alt), .caps_lock(caps_lock)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: pending bytes of the current sequence, event queue, held keys
    logic [9:0] mq[$];
    logic [7:0] pend[$];
    bit         held[512];
    int         last_key;
    int         idle_cnt;
    bit         m_ovf, m_err, m_caps;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_pfx(input logic [7:0] b);
        return b == 8'hE0 || b == 8'hF0 || b == 8'hE1;
    endfunction

    function automatic bit is_fill(input logic [7:0] b);
        return b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE || b == 8'h00 || b == 8'hFF;
    endfunction

    // Applies a decoded key event to modifiers/filter; returns 1 if it must be queued
    function automatic bit m_event(input bit ext, input bit brk, input logic [7:0] code);
        int k;
        k = (ext ? 256 : 0) + int'(code);
        if (!brk && k == 'h058 && !held[k]) m_caps = ~m_caps;
        held[k] = !brk;
        if (brk) begin
            if (last_key == k) last_key = -1;
            return 1'b1;
        end
        if (last_key == k) return 1'b0;
        last_key = k;
        return 1'b1;
    endfunction

    task automatic model_reset();
        mq.delete();
        pend.delete();
        for (int i = 0; i < 512; i++) held[i] = 1'b0;
        last_key = -1;
        idle_cnt = 0;
        m_ovf = 0; m_err = 0; m_caps = 0;
    endtask

    task automatic model_step(input bit t, input logic [7:0] b, input bit rd, input bit clr);
        bit push, pop_ok, acc;
        logic [9:0] w;
        push = 0; w = '0; m_err = 0;
        if (t) begin
            idle_cnt = 0;
            if (pend.size() == 0) begin
                if (is_pfx(b)) pend.push_back(b);
                else if (!is_fill(b)) begin push = m_event(0, 0, b); w = {2'b00, b}; end
            end else if (pend[0] == 8'hE1) begin
                pend.push_back(b);
                if (pend.size() == 8) begin
                    pend.delete();
                    push = m_event(1, 0, 8'h77); w = 10'h277;
                end
            end else if (pend.size() == 1 && pend[0] == 8'hF0) begin
                pend.delete();
                if (is_pfx(b)) m_err = 1;
                else begin push = m_event(0, 1, b); w = {2'b01, b}; end
            end else if (pend.size() == 1) begin
                if (b == 8'hF0) pend.push_back(b);
                else begin
                    pend.delete();
                    if (b == 8'h12) ;
                    else if (is_pfx(b)) m_err = 1;
                    else begin push = m_event(1, 0, b); w = {2'b10, b}; end
                end
            end else begin
                pend.delete();
                if (b == 8'h12) ;
                else if (is_pfx(b)) m_err = 1;
                else begin push = m_event(1, 1, b); w = {2'b11, b}; end
            end
        end else if (pend.size() != 0) begin
            idle_cnt++;
            if (idle_cnt == TOC) begin
                m_err = 1;
                pend.delete();
                idle_cnt = 0;
            end
        end
        pop_ok = rd && mq.size() > 0;
        acc    = push && (mq.size() < DEPTH || pop_ok);
        if (clr) m_ovf = 0;
        if (push && !acc) m_ovf = 1;
        if (pop_ok) void'(mq.pop_front());
        if (acc) mq.push_back(w);
    endtask

    task automatic compare();
        check("ev_empty", ev_empty, mq.size() == 0);
        if (mq.size() != 0) check("ev_data", ev_data, mq[0]);
        check("rx_en", rx_en, mq.size() < DEPTH);
        check("ev_ovf", ev_ovf, m_ovf);
        check("seq_err", seq_err, m_err);
        check("shift", shift, held['h012] | held['h059]);
        check("ctrl", ctrl, held['h014] | held['h114]);
        check("alt", alt, held['h011] | held['h111]);
        check("caps_lock", caps_lock, m_caps);
    endtask

    task automatic step(input bit t, input logic [7:0] b, input bit rd, input bit clr);
        rx_done_tick = t; scan_code = b; ev_rd = rd; ovf_clr = clr;
        model_step(t, b, rd, clr);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0);
    endtask

    task automatic send(input logic [7:0] b);
        step(1, b, 0, 0);
        idle(2);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && ev_empty === 1'b0; i++) step(0, 8'h00, 1, 0);
        check("drain_empty", ev_empty, 1);
    endtask

    task automatic pop_expect(input logic [9:0] exp);
        check("pop_data", ev_data, exp);
        step(0, 8'h00, 1, 0);
    endtask

    logic [7:0] pool[16] = '{8'h12, 8'h59, 8'h14, 8'h11, 8'h58, 8'h1C, 8'h15, 8'h1D,
                             8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'h77, 8'h75, 8'hF0, 8'hE0};

    initial begin
        int n;
        model_reset();
        reset = 1'b0; rx_done_tick = 0; scan_code = 0; ev_rd = 0; ovf_clr = 0;
        #22;
        check("rst_empty", ev_empty, 1);
        check("rst_data", ev_data, 0);
        check("rst_rx_en", rx_en, 1);
        check("rst_outs", {ev_ovf, seq_err, shift, ctrl, alt, caps_lock}, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Basic make, typematic repeat, break
        check("pre_tick_empty", ev_empty, 1);
        step(1, 8'h1C, 0, 0);
        check("first_ev_empty", ev_empty, 0);
        check("first_ev_data", ev_data, 10'h01C);
        idle(20);
        send(8'h1C); send(8'hF0); send(8'h1C);
        pop_expect(10'h01C);
        pop_expect(10'h11C);
        check("only_two", ev_empty, 1);

        // Extended make/break and fake shift
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        pop_expect(10'h275);
        pop_expect(10'h375);
        send(8'hE0); send(8'h12);
        check("fake_shift", ev_empty, 1);

        // Modifiers and caps lock
        send(8'h12); check("shift_l", shift, 1); drain();
        send(8'h59); send(8'hF0); send(8'h12); check("shift_r_held", shift, 1); drain();
        send(8'hF0); send(8'h59); check("shift_off", shift, 0); drain();
        send(8'h58); check("caps1", caps_lock, 1);
        send(8'h58); check("caps2", caps_lock, 1); drain();
        send(8'hF0); send(8'h58); check("caps3", caps_lock, 1);
        send(8'h58); check("caps4", caps_lock, 0); drain();

        // Pause sequence
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        pop_expect(10'h277);
        check("pause_single", ev_empty, 1);

        // Timeout abort
        step(1, 8'hE0, 0, 0);
        n = 0;
        for (int i = 1; i <= TOC + 10; i++) begin
            step(0, 8'h00, 0, 0);
            if (seq_err === 1'b1) begin
                n++;
                check("timeout_cycle", i, TOC);
            end
        end
        check("timeout_pulses", n, 1);
        send(8'h1C);
        pop_expect(10'h01C);

        // Overflow
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
        check("full_rx_en", rx_en, 0);
        send(8'h2C);
        check("ovf_set", ev_ovf, 1);
        pop_expect(10'h015); pop_expect(10'h01D); pop_expect(10'h024); pop_expect(10'h02D);
        check("ovf_kept", ev_ovf, 1);
        step(0, 8'h00, 0, 1);
        check("ovf_clr", ev_ovf, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 9) < 7) ? pool[$urandom_range(0, 15)] : 8'($urandom);
            if (i < 2000)
                step($urandom_range(0, 2) == 0, b, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
            else
                step($urandom_range(0, 1) == 0, b, $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0);
        end
        drain();

        // Reset mid-sequence with queued events and a held modifier
        send(8'h12); send(8'h33); send(8'hE0);
        check("pre_reset_queued", ev_empty, 0);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_empty", ev_empty, 1);
        check("mid_rst_data", ev_data, 0);
        check("mid_rst_rx_en", rx_en, 1);
        check("mid_rst_outs", {ev_ovf, seq_err, shift, ctrl, alt, caps_lock}, 0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        send(8'h1C);
        pop_expect(10'h01C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
